// File: rtl/heap_array_writer_if.sv
// Command channel of the heap array writer.
//
// Bundles the valid/ready command handshake and the completion strobe.
//   master : drives cmd_valid/cmd_op/cmd_array/cmd_index/cmd_data,
//            observes cmd_ready/done/err
//   slave  : the writer itself
// Signals:
//   cmd_valid  command present
//   cmd_ready  writer can accept a command this cycle
//   cmd_op     0 SET, 1 PUSH, 2 INSERT, 3 RESIZE, 4 CLEAR, 5-7 illegal
//   cmd_array  target array
//   cmd_index  element index (SET/INSERT) or new size (RESIZE)
//   cmd_data   value to write
//   done       one-cycle completion pulse
//   err        qualifies done; 1 = command rejected, nothing changed
interface heap_array_writer_if #(
  parameter int MemoryElementWidth = 12,
  parameter int ArrayWidth         = 4,
  parameter int IndexWidth         = 4
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [2:0]                    cmd_op;
  logic [ArrayWidth-1:0]         cmd_array;
  logic [IndexWidth-1:0]         cmd_index;
  logic [MemoryElementWidth-1:0] cmd_data;
  logic                          done;
  logic                          err;

  modport master (
    output cmd_valid, cmd_op, cmd_array, cmd_index, cmd_data,
    input  cmd_ready, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_array, cmd_index, cmd_data,
    output cmd_ready, done, err
  );
endinterface

// File: rtl/heap_array_writer.sv
// Sequential writer for the heap array store.
//
// Holds a flat heap of NArrays x NArea elements (address = array*NArea +
// index) plus a per-array size table, and applies SET / PUSH / INSERT /
// RESIZE / CLEAR commands. Multi-element operations (insert shift, clear)
// touch one element per clock.
//
// Ports:
//   clock     single clock, posedge
//   reset     synchronous, active-high; clears sizes and control, not heap
//   cmd       heap_array_writer_if.slave command channel (valid/ready,
//             op/array/index/data, done/err completion pulse)
//   rd_array  read array select
//   rd_index  read element select
//   rd_data   registered heap[rd_array*NArea+rd_index], 0 when out of range
//   rd_size   registered size of rd_array, 0 when out of range
//
// Optional feature macro: HEAP_ARRAY_WRITER_ZERO_ON_SHRINK_EN
//   When defined, a RESIZE that shrinks an array zeroes the dropped
//   elements (state ZERO, one element per cycle) before committing the size.
module heap_array_writer #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 10,
  parameter int NArrays            = 16,
  parameter int ArrayWidth         = 4,
  parameter int IndexWidth         = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  heap_array_writer_if.slave            cmd,
  input  logic [ArrayWidth-1:0]         rd_array,
  input  logic [IndexWidth-1:0]         rd_index,
  output logic [MemoryElementWidth-1:0] rd_data,
  output logic [IndexWidth-1:0]         rd_size
);

  localparam int Depth = NArrays * NArea;
  localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef logic [IndexWidth-1:0]         idx_t;
  typedef logic [ArrayWidth-1:0]         arr_t;
  typedef logic [MemoryElementWidth-1:0] elem_t;
  typedef logic [AddrW-1:0]              addr_t;

  localparam logic [2:0] OpSet    = 3'd0;
  localparam logic [2:0] OpPush   = 3'd1;
  localparam logic [2:0] OpInsert = 3'd2;
  localparam logic [2:0] OpResize = 3'd3;
  localparam logic [2:0] OpClear  = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WRITE,
    CLEAR,
`ifdef HEAP_ARRAY_WRITER_ZERO_ON_SHRINK_EN
    ZERO,
`endif
    DONE
  } state_t;

  function automatic addr_t addr_of(input arr_t a, input idx_t i);
    int flat;
    flat = int'(a) * NArea + int'(i);
    return addr_t'(flat);
  endfunction

  state_t state, state_n;

  elem_t heap  [Depth];
  idx_t  sizes [NArrays];

  // Command captured at acceptance.
  logic [2:0] op_q;
  arr_t       arr_q;
  idx_t       pos_q;    // element written in WRITE, or new size for RESIZE
  idx_t       cnt_q;    // walking element pointer for SHIFT / CLEAR / ZERO
  elem_t      data_q;
  logic       err_q;

  logic  accept;
  logic  arr_ok;
  idx_t  cur_size;
  logic  cmd_err;
  idx_t  sz_q;          // live size of the captured array

  logic  wr_en;
  addr_t wr_addr;
  elem_t wr_data;
  logic  size_we;
  idx_t  size_nxt;

  elem_t rd_data_p1;
  idx_t  rd_size_p1;

  assign accept   = cmd.cmd_valid && (state == IDLE);
  assign arr_ok   = int'(cmd.cmd_array) < NArrays;
  assign cur_size = arr_ok ? sizes[cmd.cmd_array] : '0;
  assign sz_q     = sizes[arr_q];

  always_comb begin
    cmd_err = 1'b0;
    if (!arr_ok) begin
      cmd_err = 1'b1;
    end else begin
      case (cmd.cmd_op)
        OpSet:    cmd_err = int'(cmd.cmd_index) >= NArea;
        OpPush:   cmd_err = int'(cur_size) == NArea;
        OpInsert: cmd_err = (int'(cur_size) == NArea) || (cmd.cmd_index > cur_size);
        OpResize: cmd_err = int'(cmd.cmd_index) > NArea;
        OpClear:  cmd_err = 1'b0;
        default:  cmd_err = 1'b1;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_err) begin
            state_n = DONE;
          end else begin
            case (cmd.cmd_op)
              OpInsert: state_n = (cmd.cmd_index == cur_size) ? WRITE : SHIFT;
`ifdef HEAP_ARRAY_WRITER_ZERO_ON_SHRINK_EN
              OpResize: state_n = (cmd.cmd_index < cur_size) ? ZERO : WRITE;
`endif
              OpClear:  state_n = CLEAR;
              default:  state_n = WRITE;
            endcase
          end
        end
      end
      // cnt_q is the destination slot; the slot just above index is last.
      SHIFT:   if (cnt_q == pos_q + idx_t'(1)) state_n = WRITE;
      CLEAR:   if (int'(cnt_q) == NArea - 1)   state_n = DONE;
`ifdef HEAP_ARRAY_WRITER_ZERO_ON_SHRINK_EN
      ZERO:    if (cnt_q == sz_q - idx_t'(1))  state_n = WRITE;
`endif
      WRITE:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd.cmd_ready = (state == IDLE);
    cmd.done      = (state == DONE);
    cmd.err       = (state == DONE) && err_q;
  end

  // Heap write port and size-table update. Writes are suppressed while
  // reset is asserted so an aborted operation stops on the reset edge.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = addr_of(arr_q, cnt_q);
    wr_data  = '0;
    size_we  = 1'b0;
    size_nxt = sz_q;
    case (state)
      SHIFT: begin
        wr_en   = 1'b1;
        wr_data = heap[addr_of(arr_q, cnt_q - idx_t'(1))];
      end
      CLEAR: begin
        wr_en = 1'b1;
        if (int'(cnt_q) == NArea - 1) begin
          size_we  = 1'b1;
          size_nxt = '0;
        end
      end
`ifdef HEAP_ARRAY_WRITER_ZERO_ON_SHRINK_EN
      ZERO: wr_en = 1'b1;
`endif
      WRITE: begin
        wr_en   = (op_q != OpResize);
        wr_addr = addr_of(arr_q, pos_q);
        wr_data = data_q;
        size_we = 1'b1;
        case (op_q)
          OpSet:    size_nxt = (pos_q >= sz_q) ? pos_q + idx_t'(1) : sz_q;
          OpResize: size_nxt = pos_q;
          default:  size_nxt = sz_q + idx_t'(1);
        endcase
      end
      default: ;
    endcase
    if (reset) wr_en = 1'b0;
  end

  // Command capture and element pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= cmd_err;
    end
    if (accept) begin
      op_q   <= cmd.cmd_op;
      arr_q  <= cmd.cmd_array;
      data_q <= cmd.cmd_data;
      pos_q  <= (cmd.cmd_op == OpPush) ? cur_size : cmd.cmd_index;
      case (cmd.cmd_op)
        OpInsert: cnt_q <= cur_size;
        OpClear:  cnt_q <= '0;
        default:  cnt_q <= cmd.cmd_index;
      endcase
    end else begin
      case (state)
        SHIFT:   cnt_q <= cnt_q - idx_t'(1);
        CLEAR:   cnt_q <= cnt_q + idx_t'(1);
`ifdef HEAP_ARRAY_WRITER_ZERO_ON_SHRINK_EN
        ZERO:    cnt_q <= cnt_q + idx_t'(1);
`endif
        default: ;
      endcase
    end
  end

  // Heap storage, never reset
  always_ff @(posedge clock) begin
    if (wr_en) heap[wr_addr] <= wr_data;
  end

  // Size table and registered read port (p1 = one cycle after address)
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < NArrays; a++) sizes[a] <= '0;
      rd_data_p1 <= '0;
      rd_size_p1 <= '0;
    end else begin
      if (size_we) sizes[arr_q] <= size_nxt;
      if ((int'(rd_array) < NArrays) && (int'(rd_index) < NArea))
        rd_data_p1 <= heap[addr_of(rd_array, rd_index)];
      else
        rd_data_p1 <= '0;
      rd_size_p1 <= (int'(rd_array) < NArrays) ? sizes[rd_array] : '0;
    end
  end

  assign rd_data = rd_data_p1;
  assign rd_size = rd_size_p1;

endmodule

// File: tb/tb_heap_array_writer.sv
// Scoreboard bench for heap_array_writer: commands are issued with a
// reference model of the arrays; each issue queues the expected err flag
// and done cycle, and a monitor matches them against done pulses.
module tb_heap_array_writer;
  localparam int MEW  = 12;
  localparam int NA   = 10;
  localparam int NARR = 16;
  localparam int AW   = 4;
  localparam int IW   = 4;

  localparam logic [2:0] SET = 3'd0, PUSH = 3'd1, INSERT = 3'd2,
                         RESIZE = 3'd3, CLEAR = 3'd4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0]  rd_array;
  logic [IW-1:0]  rd_index;
  logic [MEW-1:0] rd_data;
  logic [IW-1:0]  rd_size;

  always #5 clock = ~clock;

  heap_array_writer_if #(.MemoryElementWidth(MEW), .ArrayWidth(AW), .IndexWidth(IW)) cif();

  heap_array_writer #(
    .MemoryElementWidth(MEW), .NArea(NA), .NArrays(NARR),
    .ArrayWidth(AW), .IndexWidth(IW)
  ) dut (
    .clock(clock), .reset(reset), .cmd(cif),
    .rd_array(rd_array), .rd_index(rd_index),
    .rd_data(rd_data), .rd_size(rd_size)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: array contents and sizes
  logic [MEW-1:0] mem [NARR][NA];
  int             msz [NARR];

  typedef struct { bit err; int cyc; } exp_t;
  exp_t sb[$];

  task automatic model_cmd(input logic [2:0] op, input int a, input int i,
                           input logic [MEW-1:0] d, output bit e, output int lat);
    logic [MEW-1:0] q[$];
    e = 1'b0;
    lat = 2;
    case (op)
      SET: begin
        if (i >= NA) e = 1'b1;
        else begin
          mem[a][i] = d;
          if (i + 1 > msz[a]) msz[a] = i + 1;
        end
      end
      PUSH: begin
        if (msz[a] == NA) e = 1'b1;
        else begin mem[a][msz[a]] = d; msz[a]++; end
      end
      INSERT: begin
        if (msz[a] == NA || i > msz[a]) e = 1'b1;
        else begin
          q = {};
          for (int k = 0; k < msz[a]; k++) q.push_back(mem[a][k]);
          q.insert(i, d);
          for (int k = 0; k < q.size(); k++) mem[a][k] = q[k];
          lat = 2 + msz[a] - i;
          msz[a]++;
        end
      end
      RESIZE: begin
        if (i > NA) e = 1'b1;
        else begin
`ifdef HEAP_ARRAY_WRITER_ZERO_ON_SHRINK_EN
          if (i < msz[a]) begin
            lat = 2 + msz[a] - i;
            for (int k = i; k < msz[a]; k++) mem[a][k] = '0;
          end
`endif
          msz[a] = i;
        end
      end
      CLEAR: begin
        for (int k = 0; k < NA; k++) mem[a][k] = '0;
        msz[a] = 0;
        lat = NA + 1;
      end
      default: e = 1'b1;
    endcase
    if (e) lat = 1;
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clock) begin
    exp_t x;
    if (cif.done) begin
      if (sb.size() == 0) chk("unexpected_done", cif.done, 0);
      else begin
        x = sb.pop_front();
        chk("done_err", cif.err, x.err);
        chk("done_cycle", cyc, x.cyc);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input int a, input int i, input logic [MEW-1:0] d);
    bit e;
    int lat;
    int n;
    n = 0;
    @(negedge clock);
    while (!cif.cmd_ready && n < 100) begin @(negedge clock); n++; end
    if (!cif.cmd_ready) begin
      chk("ready_timeout", cif.cmd_ready, 1);
      return;
    end
    model_cmd(op, a, i, d, e, lat);
    cif.cmd_op    = op;
    cif.cmd_array = AW'(a);
    cif.cmd_index = IW'(i);
    cif.cmd_data  = d;
    cif.cmd_valid = 1'b1;
    sb.push_back('{e, cyc + lat});
    @(posedge clock);
    #1;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 3'($urandom);
    cif.cmd_array = AW'($urandom);
    cif.cmd_index = IW'($urandom);
    cif.cmd_data  = MEW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clock); n++; end
    while ((sb.size() != 0 || !cif.cmd_ready) && n < 500);
    chk("drain", sb.size(), 0);
  endtask

  task automatic do_read(input int a, input int i, output logic [MEW-1:0] d, output logic [IW-1:0] s);
    @(negedge clock);
    rd_array = AW'(a);
    rd_index = IW'(i);
    @(negedge clock);
    d = rd_data;
    s = rd_size;
  endtask

  task automatic check_read(input int a, input int i);
    logic [MEW-1:0] d;
    logic [IW-1:0]  s;
    logic [MEW-1:0] ed;
    do_read(a, i, d, s);
    ed = (i < NA) ? mem[a][i] : '0;
    chk($sformatf("rd_data[%0d][%0d]", a, i), d, ed);
    chk($sformatf("rd_size[%0d]", a), s, msz[a]);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, got %0d of %0d checks", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [MEW-1:0] d;
    logic [IW-1:0]  s;
    int r, a, i;
    logic [2:0] op;

    cif.cmd_valid = 1'b0;
    cif.cmd_op    = '0;
    cif.cmd_array = '0;
    cif.cmd_index = '0;
    cif.cmd_data  = '0;
    rd_array = '0;
    rd_index = '0;
    for (int k = 0; k < NARR; k++) begin
      msz[k] = 0;
      for (int j = 0; j < NA; j++) mem[k][j] = '0;
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_ready", cif.cmd_ready, 1);
    chk("reset_done", cif.done, 0);
    chk("reset_err", cif.err, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_size", rd_size, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Heap contents are not reset; start from a known state.
    for (int k = 0; k < NARR; k++) issue(CLEAR, k, 0, '0);
    wait_idle();

    // Three pushes
    issue(PUSH, 0, 0, 12'd10);
    issue(PUSH, 0, 0, 12'd20);
    issue(PUSH, 0, 0, 12'd30);
    wait_idle();
    for (int k = 0; k < 3; k++) check_read(0, k);
    do_read(0, 1, d, s);
    chk("push_elem1", d, 20);
    chk("push_size", s, 3);

    // Insert with shift; not ready while busy
    issue(INSERT, 0, 1, 12'd15);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("ready_while_busy", cif.cmd_ready, 0);
    end
    wait_idle();
    for (int k = 0; k < 4; k++) check_read(0, k);
    do_read(0, 1, d, s);
    chk("insert_elem1", d, 15);
    chk("insert_size", s, 4);

    // Full array: push and insert rejected
    for (int k = 0; k < NA; k++) issue(PUSH, 3, 0, MEW'(100 + k));
    issue(PUSH, 3, 0, 12'd999);
    issue(INSERT, 3, 5, 12'd1);
    wait_idle();
    check_read(3, 9);
    do_read(3, 0, d, s);
    chk("full_size", s, 10);
    chk("full_elem0", d, 100);

    // SET on an empty array, then out-of-range SET
    issue(SET, 2, 7, 12'd99);
    issue(SET, 2, 10, 12'd5);
    wait_idle();
    do_read(2, 7, d, s);
    chk("set_elem7", d, 99);
    chk("set_size", s, 8);
    check_read(2, 0);
    check_read(2, 12);

    // Shrinking resize
    issue(RESIZE, 0, 2, '0);
    wait_idle();
    do_read(0, 2, d, s);
    chk("resize_size", s, 2);
`ifdef HEAP_ARRAY_WRITER_ZERO_ON_SHRINK_EN
    chk("resize_elem2", d, 0);
`else
    chk("resize_elem2", d, 20);
`endif
    check_read(0, 3);

    // Random traffic on arrays 0..3
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      a = $urandom_range(0, 3);
      i = $urandom_range(0, 11);
      if (r < 6)       op = PUSH;
      else if (r < 10) op = INSERT;
      else if (r < 13) op = SET;
      else if (r < 16) op = RESIZE;
      else if (r < 17) op = CLEAR;
      else if (r < 18) op = 3'($urandom_range(5, 7));
      else             op = PUSH;
      issue(op, a, i, MEW'($urandom));
      if (n % 10 == 9) begin
        wait_idle();
        for (int k = 0; k < 3; k++) check_read($urandom_range(0, 3), $urandom_range(0, 15));
      end
    end
    wait_idle();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < NA; j++) check_read(k, j);

    // Reset during the shift of an insert on a size-9 array
    for (int k = 0; k < 9; k++) issue(PUSH, 5, 0, MEW'(200 + k));
    wait_idle();
    issue(INSERT, 5, 0, 12'd77);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    sb.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < NARR; k++) msz[k] = 0;
    @(negedge clock);
    chk("abort_ready", cif.cmd_ready, 1);
    chk("abort_done", cif.done, 0);
    for (int k = 0; k < NARR; k++) begin
      do_read(k, 0, d, s);
      chk($sformatf("abort_size[%0d]", k), s, 0);
    end
    issue(CLEAR, 5, 0, '0);
    wait_idle();
    for (int j = 0; j < NA; j++) begin
      do_read(5, j, d, s);
      chk($sformatf("clear_elem[%0d]", j), d, 0);
    end
    for (int j = 0; j < NA; j++) check_read(1, j);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
